// File: rtl/blob_centroid_tracker.sv
// rtl/blob_centroid_tracker.sv - frame centroid of thresholded hit pixels with noisy-row rejection
module blob_centroid_tracker #(
    parameter int IMG_W    = 640,
    parameter int IMG_H    = 480,
    parameter int COLOR_W  = 12,
    parameter int COORD_W  = 11,
    parameter int MIN_RUN  = 5,
    parameter int MIN_ROWS = 5
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic [COLOR_W-1:0] iColor,
    input  logic               iDVAL,
    input  logic               iSOF,
    output logic [COORD_W-1:0] oCol,
    output logic [COORD_W-1:0] oRow,
    output logic               oVALID_COORD,
    output logic               oPresent,
    output logic               oDROP
);

    localparam int ROW_CNT_W = $clog2(IMG_W + 1);
    localparam int ROW_SUM_W = ROW_CNT_W + COORD_W;
    localparam int CNT_W     = $clog2(IMG_W * IMG_H + 1);
    localparam int SUM_W     = CNT_W + COORD_W;
    localparam int ROWS_W    = $clog2(IMG_H + 1);
    localparam int ITER_W    = $clog2(COORD_W + 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DIV, S_OUT} state_t;

    state_t state_q, state_d;

    logic [COORD_W-1:0]   col, row, cur_col, cur_row;
    logic                 sof, hit, last_col, last_row, frame_end, frame_end_d, commit;
    logic [ROW_CNT_W-1:0] row_cnt, row_cnt_nx;
    logic [ROW_SUM_W-1:0] row_xsum, row_ysum, row_xsum_nx, row_ysum_nx;
    logic [CNT_W-1:0]     frame_cnt, frame_cnt_nx;
    logic [SUM_W-1:0]     frame_xsum, frame_ysum, frame_xsum_nx, frame_ysum_nx;
    logic [ROWS_W-1:0]    act_rows, act_rows_nx;
    logic                 frame_clr, present_now, present_q;
    logic [CNT_W-1:0]     divisor;
    logic [SUM_W-1:0]     x_rem, y_rem, dsr;
    logic                 x_ge, y_ge;
    logic [COORD_W-1:0]   qx, qy;
    logic [ITER_W-1:0]    iter;
    logic                 load_en, div_en, out_en, drop;

    // The SOF pixel is treated as (0,0) and starts with empty accumulators.
    always_comb begin
        sof         = iDVAL & iSOF;
        hit         = |iColor;
        cur_col     = sof ? '0 : col;
        cur_row     = sof ? '0 : row;
        last_col    = (cur_col == COORD_W'(IMG_W - 1));
        last_row    = (cur_row == COORD_W'(IMG_H - 1));
        frame_end   = iDVAL & last_col & last_row;
        row_cnt_nx  = (sof ? '0 : row_cnt) + ROW_CNT_W'(hit);
        row_xsum_nx = (sof ? '0 : row_xsum) + (hit ? ROW_SUM_W'(cur_col) : '0);
        row_ysum_nx = (sof ? '0 : row_ysum) + (hit ? ROW_SUM_W'(cur_row) : '0);
        commit      = iDVAL & last_col & (row_cnt_nx >= ROW_CNT_W'(MIN_RUN));
        frame_clr   = sof | frame_end_d;
        frame_cnt_nx  = (frame_clr ? '0 : frame_cnt)  + (commit ? CNT_W'(row_cnt_nx)  : '0);
        frame_xsum_nx = (frame_clr ? '0 : frame_xsum) + (commit ? SUM_W'(row_xsum_nx) : '0);
        frame_ysum_nx = (frame_clr ? '0 : frame_ysum) + (commit ? SUM_W'(row_ysum_nx) : '0);
        act_rows_nx   = (frame_clr ? '0 : act_rows)   + ROWS_W'(commit);
        present_now = (act_rows >= ROWS_W'(MIN_ROWS));
        divisor     = present_now ? frame_cnt : CNT_W'(1);
        x_ge        = (x_rem >= dsr);
        y_ge        = (y_rem >= dsr);
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            col         <= '0;
            row         <= '0;
            row_cnt     <= '0;
            row_xsum    <= '0;
            row_ysum    <= '0;
            frame_cnt   <= '0;
            frame_xsum  <= '0;
            frame_ysum  <= '0;
            act_rows    <= '0;
            frame_end_d <= 1'b0;
        end else begin
            frame_end_d <= frame_end;
            frame_cnt   <= frame_cnt_nx;
            frame_xsum  <= frame_xsum_nx;
            frame_ysum  <= frame_ysum_nx;
            act_rows    <= act_rows_nx;
            if (iDVAL) begin
                col      <= last_col ? '0 : cur_col + COORD_W'(1);
                row      <= last_col ? (last_row ? '0 : cur_row + COORD_W'(1)) : cur_row;
                row_cnt  <= last_col ? '0 : row_cnt_nx;
                row_xsum <= last_col ? '0 : row_xsum_nx;
                row_ysum <= last_col ? '0 : row_ysum_nx;
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (frame_end) state_d = S_LOAD;
            S_LOAD:  state_d = S_DIV;
            S_DIV:   if (iter == ITER_W'(COORD_W - 1)) state_d = S_OUT;
            S_OUT:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        load_en = (state_q == S_LOAD);
        div_en  = (state_q == S_DIV);
        out_en  = (state_q == S_OUT);
        drop    = frame_end & (state_q != S_IDLE);
    end

    // Quotients are below 2^COORD_W, so the divisor starts shifted by COORD_W-1.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            present_q <= 1'b0;
            x_rem     <= '0;
            y_rem     <= '0;
            dsr       <= '0;
            qx        <= '0;
            qy        <= '0;
            iter      <= '0;
        end else if (load_en) begin
            present_q <= present_now;
            x_rem     <= frame_xsum;
            y_rem     <= frame_ysum;
            dsr       <= SUM_W'({divisor, {(COORD_W - 1){1'b0}}});
            qx        <= '0;
            qy        <= '0;
            iter      <= '0;
        end else if (div_en) begin
            if (x_ge) x_rem <= x_rem - dsr;
            if (y_ge) y_rem <= y_rem - dsr;
            qx   <= {qx[COORD_W-2:0], x_ge};
            qy   <= {qy[COORD_W-2:0], y_ge};
            dsr  <= dsr >> 1;
            iter <= iter + ITER_W'(1);
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            oCol         <= '0;
            oRow         <= '0;
            oPresent     <= 1'b0;
            oVALID_COORD <= 1'b0;
            oDROP        <= 1'b0;
        end else begin
            oVALID_COORD <= out_en;
            oDROP        <= drop;
            if (out_en) begin
                oPresent <= present_q;
                if (present_q) begin
                    oCol <= qx;
                    oRow <= qy;
                end
            end
        end
    end

endmodule
